// File: rtl/line_read_sched_if.sv
// line_read_sched_if -- handshake/bus bundle for line_read_sched.
//   master : testbench / upstream side (drives WR_STB, LINE_START, RD_READY[, FREEZE])
//   slave  : the scheduler (drives WADR, RADR, RVALID, RLAST, DONE, BUSY,
//            OVERRUN, LINE_MISS)
// Optional FREEZE signal exists only when LINE_READ_SCHED_FREEZE_EN is defined.
interface line_read_sched_if #(
    parameter int ABIT = 12
);
    logic            WR_STB;
    logic            LINE_START;
    logic            RD_READY;
`ifdef LINE_READ_SCHED_FREEZE_EN
    logic            FREEZE;
`endif
    logic [ABIT:0]   WADR;
    logic [ABIT-1:0] RADR;
    logic            RVALID;
    logic            RLAST;
    logic            DONE;
    logic            BUSY;
    logic            OVERRUN;
    logic            LINE_MISS;

    modport master (
        output WR_STB, LINE_START, RD_READY,
`ifdef LINE_READ_SCHED_FREEZE_EN
        output FREEZE,
`endif
        input  WADR, RADR, RVALID, RLAST, DONE, BUSY, OVERRUN, LINE_MISS
    );

    modport slave (
        input  WR_STB, LINE_START, RD_READY,
`ifdef LINE_READ_SCHED_FREEZE_EN
        input  FREEZE,
`endif
        output WADR, RADR, RVALID, RLAST, DONE, BUSY, OVERRUN, LINE_MISS
    );
endinterface

// File: rtl/line_read_sched.sv
// line_read_sched -- per-line read-address scheduler for a sample-pair buffer.
// A free-running write counter (WADR) tracks the audio writer. On LINE_START
// the pair address of WADR is snapshotted, offset, and LEN consecutive read
// pair addresses are issued on a valid/ready handshake.
// Ports:
//   CLK  : clock, rising edge
//   RST  : synchronous active-high reset
//   bus  : line_read_sched_if.slave (WR_STB, LINE_START, RD_READY in;
//          WADR, RADR, RVALID, RLAST, DONE, BUSY, OVERRUN, LINE_MISS out)
// Optional feature: define LINE_READ_SCHED_FREEZE_EN to add bus.FREEZE; a
// LINE_START with FREEZE=1 replays the previous snapshot (frozen display).
module line_read_sched #(
    parameter int ABIT   = 12,
    parameter int OFFSET = 402,
    parameter int LEN    = 800
) (
    input  logic              CLK,
    input  logic              RST,
    line_read_sched_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t          state, state_nx;
    logic [ABIT:0]   wadr;
    logic [ABIT-1:0] wadr_cap;   // pair address seen in the LINE_START cycle
    logic [ABIT-1:0] snap;
    logic [ABIT-1:0] radr;
    logic [ABIT-1:0] cnt;        // 1-based index of the address on RADR
    logic [ABIT-1:0] load_val;
    logic            overrun;
    logic            line_miss;
    logic            rvalid;
    logic            rlast;
`ifdef LINE_READ_SCHED_FREEZE_EN
    logic            frz_cap;
`endif

    assign rvalid = (state == S_RUN);
    assign rlast  = rvalid && (cnt == ABIT'(LEN));

    // The +2 accounts for the two-cycle LINE_START -> first RVALID latency.
`ifdef LINE_READ_SCHED_FREEZE_EN
    assign load_val = frz_cap ? snap : wadr_cap + ABIT'(OFFSET + 2);
`else
    assign load_val = wadr_cap + ABIT'(OFFSET + 2);
`endif

    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.LINE_START) state_nx = S_LOAD;
            S_LOAD:  state_nx = S_RUN;
            S_RUN:   if (bus.RD_READY && rlast) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wadr      <= '0;
            wadr_cap  <= '0;
            snap      <= '0;
            radr      <= '0;
            cnt       <= '0;
            overrun   <= 1'b0;
            line_miss <= 1'b0;
`ifdef LINE_READ_SCHED_FREEZE_EN
            frz_cap   <= 1'b0;
`endif
        end else begin
            if (bus.WR_STB) wadr <= wadr + 1'b1;

            // Snapshot uses the pre-increment counter even if WR_STB is high.
            if (state == S_IDLE && bus.LINE_START) begin
                wadr_cap <= wadr[ABIT:1];
`ifdef LINE_READ_SCHED_FREEZE_EN
                frz_cap  <= bus.FREEZE;
`endif
            end

            if (bus.LINE_START && state != S_IDLE) line_miss <= 1'b1;
            if (bus.WR_STB && rvalid && wadr[ABIT:1] == radr) overrun <= 1'b1;

            case (state)
                S_LOAD: begin
                    snap <= load_val;
                    radr <= load_val;
                    cnt  <= ABIT'(1);
                end
                S_RUN: begin
                    if (bus.RD_READY && cnt < ABIT'(LEN)) begin
                        radr <= radr + 1'b1;
                        cnt  <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.WADR      = wadr;
    assign bus.RADR      = radr;
    assign bus.RVALID    = rvalid;
    assign bus.RLAST     = rlast;
    assign bus.DONE      = (state == S_DONE);
    assign bus.BUSY      = (state != S_IDLE);
    assign bus.OVERRUN   = overrun;
    assign bus.LINE_MISS = line_miss;
endmodule

// File: tb/tb_line_read_sched.sv
// Directed bench for line_read_sched (ABIT=12, OFFSET=402, LEN=800) plus a
// second LEN=1 instance. Inputs change and outputs are sampled 1 ns after
// each rising edge. Expected values are hand-derived from the snapshot rule
// start = (WADR>>1) + 2 + 402 mod 4096, and last = start + LEN-1.
module tb_line_read_sched;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n;

    always #5 CLK = ~CLK;

    line_read_sched_if #(.ABIT(12)) bus ();
    line_read_sched_if #(.ABIT(12)) bus1 ();

    line_read_sched #(.ABIT(12), .OFFSET(402), .LEN(800)) dut (
        .CLK(CLK), .RST(RST), .bus(bus.slave)
    );
    line_read_sched #(.ABIT(12), .OFFSET(402), .LEN(1)) dut1 (
        .CLK(CLK), .RST(RST), .bus(bus1.slave)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance until RLAST, bounded; returns the number of edges taken.
    task automatic wait_last(output int cyc);
        cyc = 0;
        while (bus.RLAST !== 1'b1 && cyc < 3000) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        bus.WR_STB = 0; bus.LINE_START = 0; bus.RD_READY = 0;
        bus1.WR_STB = 0; bus1.LINE_START = 0; bus1.RD_READY = 0;
`ifdef LINE_READ_SCHED_FREEZE_EN
        bus.FREEZE = 0; bus1.FREEZE = 0;
`endif
        // ---- reset state
        ticks(2);
        RST = 0;
        chk("rst_wadr", 32'(bus.WADR), 0);
        chk("rst_radr", 32'(bus.RADR), 0);
        chk("rst_rvalid", 32'(bus.RVALID), 0);
        chk("rst_busy", 32'(bus.BUSY), 0);
        chk("rst_done", 32'(bus.DONE), 0);
        chk("rst_ovr", 32'(bus.OVERRUN), 0);
        chk("rst_miss", 32'(bus.LINE_MISS), 0);

        // ---- basic line: WADR=10 -> start 5+404=409, last 1208
        bus.WR_STB = 1; ticks(10); bus.WR_STB = 0;
        chk("wadr10", 32'(bus.WADR), 10);
        bus.RD_READY = 1;
        bus.LINE_START = 1; tick(); bus.LINE_START = 0;
        chk("load_busy", 32'(bus.BUSY), 1);
        chk("load_rvalid", 32'(bus.RVALID), 0);
        tick();
        chk("l1_rvalid", 32'(bus.RVALID), 1);
        chk("l1_radr", 32'(bus.RADR), 409);
        chk("l1_rlast0", 32'(bus.RLAST), 0);
        wait_last(n);
        chk("l1_cycles", n, 799);
        chk("l1_last_radr", 32'(bus.RADR), 1208);
        tick();
        chk("l1_done", 32'(bus.DONE), 1);
        chk("l1_done_rv", 32'(bus.RVALID), 0);
        tick();
        chk("l1_idle_done", 32'(bus.DONE), 0);
        chk("l1_idle_busy", 32'(bus.BUSY), 0);

        // ---- pair 4000: start = 4000+404 mod 4096 = 308, last 1107
        bus.WR_STB = 1; ticks(7990); bus.WR_STB = 0;
        chk("wadr8000", 32'(bus.WADR), 8000);
        bus.LINE_START = 1; tick(); bus.LINE_START = 0; tick();
        chk("l2_radr", 32'(bus.RADR), 308);
        tick();
        chk("l2_radr_next", 32'(bus.RADR), 309);
        wait_last(n);
        chk("l2_cycles", n, 798);
        chk("l2_last_radr", 32'(bus.RADR), 1107);
        ticks(2);

        // ---- pair 3600: start 4004, wraps 4095->0, 5-cycle stall, last 707
        bus.WR_STB = 1; ticks(7392); bus.WR_STB = 0;
        chk("wadr7200", 32'(bus.WADR), 7200);
        bus.LINE_START = 1; tick(); bus.LINE_START = 0; tick();
        chk("l3_radr", 32'(bus.RADR), 4004);
        ticks(91);
        chk("l3_radr_top", 32'(bus.RADR), 4095);
        tick();
        chk("l3_radr_wrap", 32'(bus.RADR), 0);
        bus.RD_READY = 0; ticks(5);
        chk("l3_stall_radr", 32'(bus.RADR), 0);
        chk("l3_stall_rv", 32'(bus.RVALID), 1);
        bus.RD_READY = 1;
        wait_last(n);
        chk("l3_cycles", n, 707);
        chk("l3_last_radr", 32'(bus.RADR), 707);
        ticks(2);

        // ---- LINE_START during RUN is a miss; line unaffected
        bus.LINE_START = 1; tick(); bus.LINE_START = 0; tick();
        chk("l4_miss0", 32'(bus.LINE_MISS), 0);
        bus.LINE_START = 1; tick(); bus.LINE_START = 0;
        chk("l4_miss1", 32'(bus.LINE_MISS), 1);
        chk("l4_radr", 32'(bus.RADR), 4005);
        wait_last(n);
        chk("l4_cycles", n, 798);
        tick();
        chk("l4_done", 32'(bus.DONE), 1);
        tick();
        // second line after DONE starts normally; hold at first address
        bus.RD_READY = 0;
        bus.LINE_START = 1; tick(); bus.LINE_START = 0; tick();
        chk("l5_radr", 32'(bus.RADR), 4004);
        chk("l5_rvalid", 32'(bus.RVALID), 1);

        // ---- overrun: write pair walks up to RADR=4004 (WADR 8008)
        bus.WR_STB = 1; ticks(808);
        chk("ovr_wadr", 32'(bus.WADR), 8008);
        chk("ovr_before", 32'(bus.OVERRUN), 0);
        tick(); bus.WR_STB = 0;
        chk("ovr_set", 32'(bus.OVERRUN), 1);
        bus.RD_READY = 1;
        wait_last(n);
        chk("l5_cycles", n, 799);
        tick();
        chk("ovr_sticky", 32'(bus.OVERRUN), 1);
        chk("miss_sticky", 32'(bus.LINE_MISS), 1);

        // ---- reset clears sticky flags; snapshot uses pre-increment WADR
        RST = 1; tick(); RST = 0;
        chk("rst2_wadr", 32'(bus.WADR), 0);
        chk("rst2_ovr", 32'(bus.OVERRUN), 0);
        chk("rst2_miss", 32'(bus.LINE_MISS), 0);
        bus.WR_STB = 1; tick();
        bus.LINE_START = 1; tick(); bus.LINE_START = 0; bus.WR_STB = 0;
        chk("l6_wadr", 32'(bus.WADR), 2);
        tick();
        chk("l6_radr", 32'(bus.RADR), 404);
        ticks(2);
        chk("l6_radr2", 32'(bus.RADR), 406);
        RST = 1; tick(); RST = 0;
        chk("l6_rst_rv", 32'(bus.RVALID), 0);
        chk("l6_rst_busy", 32'(bus.BUSY), 0);
        chk("l6_rst_radr", 32'(bus.RADR), 0);

        // ---- LEN=1 instance: one address, RLAST held until accepted
        bus1.LINE_START = 1; tick(); bus1.LINE_START = 0; tick();
        chk("len1_rv", 32'(bus1.RVALID), 1);
        chk("len1_rlast", 32'(bus1.RLAST), 1);
        chk("len1_radr", 32'(bus1.RADR), 404);
        tick();
        chk("len1_hold", 32'(bus1.RLAST), 1);
        bus1.RD_READY = 1; tick();
        chk("len1_done", 32'(bus1.DONE), 1);
        chk("len1_done_rv", 32'(bus1.RVALID), 0);

`ifdef LINE_READ_SCHED_FREEZE_EN
        // ---- freeze: second line replays first start (404), not 50+404
        RST = 1; tick(); RST = 0;
        bus.RD_READY = 1;
        bus.LINE_START = 1; tick(); bus.LINE_START = 0; tick();
        chk("frz_l1_radr", 32'(bus.RADR), 404);
        wait_last(n);
        ticks(2);
        bus.WR_STB = 1; ticks(100); bus.WR_STB = 0;
        bus.LINE_START = 1; bus.FREEZE = 1; tick();
        bus.LINE_START = 0; bus.FREEZE = 0; tick();
        chk("frz_radr", 32'(bus.RADR), 404);
        chk("frz_wadr", 32'(bus.WADR), 100);
        tick();
        RST = 1; tick(); RST = 0;
        chk("frz_rst_rv", 32'(bus.RVALID), 0);
        chk("frz_rst_busy", 32'(bus.BUSY), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
